// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI receive period sequencer.
// Holds the period state enum, the decoder aux class constants and helpers,
// and the {ch2 ctl, ch1 ctl} preamble patterns.
package hdmi_pkg;

  typedef enum logic [2:0] {
    ST_CTRL   = 3'd0,
    ST_VGUARD = 3'd1,
    ST_VIDEO  = 3'd2,
    ST_LGUARD = 3'd3,
    ST_ISLAND = 3'd4,
    ST_TGUARD = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PAT_NONE   = 2'd0,
    PAT_VIDEO  = 2'd1,
    PAT_ISLAND = 2'd2
  } pat_e;

  localparam logic [6:0] AUX_GUARD  = 7'h41;
  localparam logic [6:0] AUX_VGUARD = 7'h68;

  // Preamble patterns as {ch2 ctl, ch1 ctl}
  localparam logic [3:0] PRE_VIDEO  = 4'b0001;
  localparam logic [3:0] PRE_ISLAND = 4'b0101;

  function automatic logic is_pixel(input logic [6:0] aux);
    return aux == 7'h00;
  endfunction

  // Control characters are identified by aux[6:4] alone
  function automatic logic is_ctrl(input logic [2:0] aux_hi);
    return aux_hi == 3'b001;
  endfunction

  function automatic logic is_vguard(input logic [20:0] aux);
    return aux == {AUX_VGUARD, AUX_GUARD, AUX_VGUARD};
  endfunction

  // ch1/ch2 part of an island guard: aux[20:7]
  function automatic logic is_iguard_hi(input logic [13:0] aux_hi);
    return aux_hi == {AUX_GUARD, AUX_GUARD};
  endfunction

endpackage

// File: rtl/hdmi_preamble_det.sv
// Preamble classifier and saturating run counter.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_en             : counting allowed (sequencer in control period)
//   i_clr            : force count to zero (protocol error)
//   i_all_ctrl       : all three channels carry control characters
//   i_pat            : {ch2 ctl, ch1 ctl}
//   o_vid_ok/o_isl_ok: a full video / island preamble has been seen
module hdmi_preamble_det
  import hdmi_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_all_ctrl,
  input  logic [3:0] i_pat,
  output logic       o_vid_ok,
  output logic       o_isl_ok
);

  localparam int unsigned CW = $clog2(PREAMBLE_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  pat_e          pat_q, pat_d;
  pat_e          pat_now;

  always_comb begin
    pat_now = PAT_NONE;
    if (i_all_ctrl) begin
      if (i_pat == PRE_VIDEO)       pat_now = PAT_VIDEO;
      else if (i_pat == PRE_ISLAND) pat_now = PAT_ISLAND;
    end

    cnt_d = cnt_q;
    pat_d = pat_q;
    if (i_clr || !i_en || (pat_now == PAT_NONE)) begin
      cnt_d = '0;
      pat_d = PAT_NONE;
    end else if (pat_now != pat_q) begin
      // A different pattern starts a fresh run that includes this cycle
      cnt_d = CW'(1);
      pat_d = pat_now;
    end else if (cnt_q < CW'(PREAMBLE_LEN)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
      pat_q <= PAT_NONE;
    end else begin
      cnt_q <= cnt_d;
      pat_q <= pat_d;
    end
  end

  assign o_vid_ok = (pat_q == PAT_VIDEO)  && (cnt_q >= CW'(PREAMBLE_LEN));
  assign o_isl_ok = (pat_q == PAT_ISLAND) && (cnt_q >= CW'(PREAMBLE_LEN));

endmodule

// File: rtl/hdmi_rx_period_fsm.sv
// HDMI receive period sequencer.
// Tracks control / preamble / guard / video / data-island periods from three
// channel-aligned TMDS decoders and emits qualified pixel, packet-character
// and sync streams. All outputs are registered (1-cycle latency).
// Ports ({ch2,ch1,ch0} packing):
//   i_clk, i_reset_n          : pixel clock, async active-low reset
//   i_ctl[5:0], i_aux[20:0]   : decoder ctl / aux class outputs
//   i_pix[23:0]               : decoder pixel outputs
//   o_hsync, o_vsync          : current sync levels
//   o_video_valid, o_pix      : active-video pixel {R,G,B}
//   o_island_valid, o_island_data, o_island_sop, o_island_eop : packet chars
//   o_err                     : one-cycle protocol-violation pulse
//   o_state                   : current period state
module hdmi_rx_period_fsm
  import hdmi_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned MAX_PACKETS  = 18
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [5:0]  i_ctl,
  input  logic [20:0] i_aux,
  input  logic [23:0] i_pix,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_video_valid,
  output logic [23:0] o_pix,
  output logic        o_island_valid,
  output logic [11:0] o_island_data,
  output logic        o_island_sop,
  output logic        o_island_eop,
  output logic        o_err,
  output logic [2:0]  o_state
);

  localparam int unsigned PW = $clog2(MAX_PACKETS + 1);

  state_e          state_q, state_d;
  logic [4:0]      char_q, char_d;
  logic [PW-1:0]   pkt_q, pkt_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic            video_valid_q, video_valid_d;
  logic [23:0]     pix_q, pix_d;
  logic            island_valid_q, island_valid_d;
  logic [11:0]     island_data_q, island_data_d;
  logic            sop_q, sop_d, eop_q, eop_d;
  logic            err_q, err_d;

  logic [6:0] aux0, aux1, aux2;
  logic       all_ctrl, any_ctrl, all_pix, all_terc4;
  logic       vguard, iguard, iguard_hi;
  logic       vid_ok, isl_ok;

  assign aux0 = i_aux[6:0];
  assign aux1 = i_aux[13:7];
  assign aux2 = i_aux[20:14];

  assign all_ctrl  = is_ctrl(aux0[6:4]) && is_ctrl(aux1[6:4]) && is_ctrl(aux2[6:4]);
  assign any_ctrl  = is_ctrl(aux0[6:4]) || is_ctrl(aux1[6:4]) || is_ctrl(aux2[6:4]);
  assign all_pix   = is_pixel(aux0) && is_pixel(aux1) && is_pixel(aux2);
  assign all_terc4 = aux0[5] && aux1[5] && aux2[5];
  assign vguard    = is_vguard(i_aux);
  assign iguard_hi = is_iguard_hi(i_aux[20:7]);
  assign iguard    = iguard_hi && aux0[5] && (aux0[3:2] == 2'b11);

  hdmi_preamble_det #(.PREAMBLE_LEN(PREAMBLE_LEN)) u_pre (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_en       (state_q == ST_CTRL),
    .i_clr      (err_d),
    .i_all_ctrl (all_ctrl),
    .i_pat      (i_ctl[5:2]),
    .o_vid_ok   (vid_ok),
    .o_isl_ok   (isl_ok)
  );

  always_comb begin
    state_d        = state_q;
    char_d         = char_q;
    pkt_d          = pkt_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    video_valid_d  = 1'b0;
    pix_d          = '0;
    island_valid_d = 1'b0;
    island_data_d  = '0;
    sop_d          = 1'b0;
    eop_d          = 1'b0;
    err_d          = 1'b0;

    case (state_q)
      ST_CTRL: begin
        if (is_ctrl(aux0[6:4])) {vsync_d, hsync_d} = i_ctl[1:0];
        if (vguard) begin
          if (vid_ok) state_d = ST_VGUARD;
          else        err_d   = 1'b1;
        end else if (iguard) begin
          if (isl_ok) state_d = ST_LGUARD;
          else        err_d   = 1'b1;
        end
      end
      ST_VGUARD: begin
        if (vguard) state_d = ST_VIDEO;
        else        err_d   = 1'b1;
      end
      ST_VIDEO: begin
        if (all_pix) begin
          video_valid_d = 1'b1;
          pix_d         = i_pix;
        end else if (any_ctrl) begin
          state_d = ST_CTRL;
          if (is_ctrl(aux0[6:4])) {vsync_d, hsync_d} = i_ctl[1:0];
        end else begin
          err_d = 1'b1;
        end
      end
      ST_LGUARD: begin
        if (iguard) begin
          state_d            = ST_ISLAND;
          char_d             = '0;
          pkt_d              = '0;
          {vsync_d, hsync_d} = aux0[1:0];
        end else begin
          err_d = 1'b1;
        end
      end
      ST_ISLAND: begin
        // Trailing guard is only legal on a packet boundary after >= 1 packet;
        // it takes priority over the packet-limit check.
        if ((char_q == '0) && (pkt_q != '0) && iguard_hi) begin
          state_d = ST_TGUARD;
        end else if ((char_q == '0) && (pkt_q == PW'(MAX_PACKETS))) begin
          err_d = 1'b1;
        end else if (all_terc4) begin
          island_valid_d     = 1'b1;
          island_data_d      = {aux2[3:0], aux1[3:0], aux0[3:0]};
          sop_d              = (char_q == 5'd0);
          eop_d              = (char_q == 5'd31);
          {vsync_d, hsync_d} = aux0[1:0];
          char_d             = char_q + 5'd1;
          if (char_q == 5'd31) pkt_d = pkt_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_TGUARD: begin
        if (iguard) state_d = ST_CTRL;
        else        err_d   = 1'b1;
      end
      default: state_d = ST_CTRL;
    endcase

    if (err_d) begin
      state_d = ST_CTRL;
      char_d  = '0;
      pkt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_CTRL;
      char_q         <= '0;
      pkt_q          <= '0;
      hsync_q        <= 1'b0;
      vsync_q        <= 1'b0;
      video_valid_q  <= 1'b0;
      pix_q          <= '0;
      island_valid_q <= 1'b0;
      island_data_q  <= '0;
      sop_q          <= 1'b0;
      eop_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      char_q         <= char_d;
      pkt_q          <= pkt_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_valid_q  <= video_valid_d;
      pix_q          <= pix_d;
      island_valid_q <= island_valid_d;
      island_data_q  <= island_data_d;
      sop_q          <= sop_d;
      eop_q          <= eop_d;
      err_q          <= err_d;
    end
  end

  assign o_hsync        = hsync_q;
  assign o_vsync        = vsync_q;
  assign o_video_valid  = video_valid_q;
  assign o_pix          = pix_q;
  assign o_island_valid = island_valid_q;
  assign o_island_data  = island_data_q;
  assign o_island_sop   = sop_q;
  assign o_island_eop   = eop_q;
  assign o_err          = err_q;
  assign o_state        = state_q;

endmodule
